packet_ref_table: RTL
=====================

Name: packet_ref_table

Overview:
- Slotted frame buffer between the MAC receive path and the MAC transmit path.
- The dispatcher streams each incoming frame into a free slot while the firewall classifies its header.
- Depending on the firewall verdict, the dispatcher either invalidates the slot or streams it back out to the transmitter.
- The block owns slot allocation, per-slot length and state, and the byte storage: one write port and one read port, each in its own session.

Parameters:
- NUM_SLOTS, 4: number of frame slots (power of two, at least 2); SW = $clog2(NUM_SLOTS).
- SLOT_BYTES, 2048: byte capacity per slot (power of two); LW = $clog2(SLOT_BYTES)+1.
- DATA_W, 8: data bus width; one byte per beat.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- slot_free  out  1  wr_start would be accepted this cycle.
- free_count  out  $clog2(NUM_SLOTS+1)  number of FREE slots.
- wr_start  in  1  request a new write session.
- wr_slot  out  SW  slot allocated on accept; valid while slot_free=1.
- wr_data_valid  in  1  write beat.
- wr_data  in  DATA_W  byte to store.
- wr_finish  in  1  close the write session.
- wr_overflow  out  1  sticky per session; a byte was dropped because the slot was full.
- inv_valid  in  1  invalidate request.
- inv_slot  in  SW  slot to invalidate.
- rd_start  in  1  request a read session.
- rd_slot  in  SW  slot to read.
- rd_start_ready  out  1  no read session active.
- rd_err  out  1  one-cycle pulse; rd_start was accepted on a non-VALID slot.
- rd_valid  out  1  output byte valid.
- rd_data  out  DATA_W  output byte.
- rd_last  out  1  final byte of the frame.
- rd_ready  in  1  consumer accepts the byte.

Behaviour:
- Reset:
  - All slots FREE; no write or read session active.
  - Outputs: slot_free=1, free_count=NUM_SLOTS, wr_slot=0, wr_overflow=0, rd_start_ready=1, rd_err=0, rd_valid=0, rd_last=0, rd_data=0.
  - A reset mid-session aborts it; stored contents become don't-care.
- Per-slot state machine: FREE -> WRITING -> VALID -> READING -> FREE. Any WRITING or VALID slot may also go to FREE by invalidate. Each slot also holds a length register of LW bits.
- Allocation:
  - slot_free = at least one FREE slot AND no write session active.
  - wr_slot = lowest-index FREE slot (combinational).
  - wr_start with slot_free=1: that slot goes to WRITING, the write pointer clears to 0, wr_overflow clears.
  - wr_start with slot_free=0 is ignored.
- Write session:
  - Each wr_data_valid stores the byte at offset ptr, then ptr++.
  - When ptr==SLOT_BYTES the byte is dropped and wr_overflow is set.
  - wr_finish: length = ptr and the slot goes VALID the next cycle. If ptr==0, the slot goes FREE instead.
  - wr_data_valid and wr_finish in the same cycle: the byte is stored first and is counted in length.
  - wr_data_valid or wr_finish with no write session active is ignored.
- Invalidate:
  - WRITING slot: goes FREE and the write session is aborted; later wr_data and wr_finish are ignored until the next wr_start.
  - VALID slot: goes FREE.
  - FREE or READING slot: no effect.
  - inv_valid and wr_finish on the same slot in the same cycle: invalidate wins, slot goes FREE.
- Read session:
  - Accepted when rd_start=1 and rd_start_ready=1.
  - If the slot is VALID, it goes READING and the read session opens.
  - If the slot is not VALID, rd_err pulses the next cycle and no session opens.
  - First rd_valid is 2 cycles after accept (synchronous RAM plus output register).
  - Bytes are emitted at offsets 0..length-1; rd_last=1 only on offset length-1.
  - AXI-style hold rule: while rd_valid=1 and rd_ready=0, rd_data and rd_last stay stable. Use a skid or prefetch register; no bubbles while rd_ready is held high.
  - When the rd_last beat is accepted, the slot goes FREE and rd_start_ready goes 1 on the next cycle.
- Visibility and concurrency:
  - A slot freed in cycle N is visible in slot_free and free_count in cycle N+1.
  - free_count updates registered, at the same time as the slot states.
  - The write and read sessions run concurrently on different slots; writing and reading the same slot at once is impossible by construction.

Test Plan:
- Basic store and forward: reset; wr_start -> wr_slot=0; write 60 bytes 0x00..0x3B; wr_finish; rd_start slot 0 with rd_ready=1 -> rd_valid 2 cycles later, 60 back-to-back bytes 0x00..0x3B, rd_last only on 0x3B; slot 0 then FREE, free_count=4.
- Fill all slots: allocate 4 frames -> slots 0,1,2,3, free_count=0, slot_free=0; a 5th wr_start is ignored; invalidate slot 2 -> next wr_start gets slot 2.
- Invalidate mid-write: open slot 0, write 20 bytes, assert inv_valid slot 0 -> slot FREE, following wr_data and wr_finish ignored, slot_free=1 the next cycle.
- Backpressure: read a 10-byte frame while toggling rd_ready 1,0,0,1,... -> each byte held stable while stalled; no loss, duplication or reordering.
- Overflow and zero length:
  - Write SLOT_BYTES+3 bytes -> wr_overflow=1, length=2048, read returns the first 2048 bytes.
  - wr_start immediately followed by wr_finish -> slot returns FREE.
- Error and collisions:
  - rd_start on a FREE slot -> rd_err pulses once, rd_start_ready stays 1.
  - wr_finish and inv_valid on the same slot in the same cycle -> slot FREE.

Source files
------------

// File: rtl/packet_ref_table.sv
// Slotted frame buffer: slot allocation, per-slot length/state and byte storage
// with one write session and one read session running concurrently.
module packet_ref_table #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SLOT_BYTES = 2048,
  parameter int unsigned DATA_W     = 8,
  localparam int unsigned SW = $clog2(NUM_SLOTS),
  localparam int unsigned LW = $clog2(SLOT_BYTES) + 1,
  localparam int unsigned CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              slot_free,
  output logic [CW-1:0]     free_count,
  input  logic              wr_start,
  output logic [SW-1:0]     wr_slot,
  input  logic              wr_data_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_finish,
  output logic              wr_overflow,
  input  logic              inv_valid,
  input  logic [SW-1:0]     inv_slot,
  input  logic              rd_start,
  input  logic [SW-1:0]     rd_slot,
  output logic              rd_start_ready,
  output logic              rd_err,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready
);

  localparam int unsigned OW    = LW - 1;
  localparam int unsigned AW    = SW + OW;
  localparam int unsigned DEPTH = NUM_SLOTS * SLOT_BYTES;

  typedef enum logic [1:0] {S_FREE, S_WRITING, S_VALID, S_READING} slot_state_e;

  slot_state_e       state_q [NUM_SLOTS];
  slot_state_e       state_d [NUM_SLOTS];
  logic [LW-1:0]     len_q   [NUM_SLOTS];
  logic [LW-1:0]     len_d   [NUM_SLOTS];
  logic [CW-1:0]     free_count_q, free_count_d;

  logic              wr_active_q, wr_active_d;
  logic [SW-1:0]     wr_cur_q, wr_cur_d;
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              wr_ovf_q, wr_ovf_d;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;

  logic              rd_active_q, rd_active_d;
  logic [SW-1:0]     rd_cur_q, rd_cur_d;
  logic [LW-1:0]     rd_fptr_q, rd_fptr_d;
  logic              rd_err_q, rd_err_d;
  logic              rd_accept, pop, credit_ok, issue, issue_last;
  logic [1:0]        occ;
  logic [AW-1:0]     mem_raddr;

  logic              ram_vld_q, ram_last_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              any_free;
  logic [SW-1:0]     first_free;

  logic [DATA_W-1:0] mem [DEPTH];

  // Lowest-index FREE slot (descending scan so the lowest index wins)
  always_comb begin
    any_free   = 1'b0;
    first_free = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (state_q[i] == S_FREE) begin
        any_free   = 1'b1;
        first_free = SW'(i);
      end
    end
  end

  assign slot_free      = any_free && !wr_active_q;
  assign wr_slot        = first_free;
  assign free_count     = free_count_q;
  assign wr_overflow    = wr_ovf_q;
  assign rd_start_ready = !rd_active_q;
  assign rd_err         = rd_err_q;
  assign rd_valid       = out_vld_q;
  assign rd_data        = out_data_q;
  assign rd_last        = out_last_q;

  // Next-state: write session, invalidate, read session, output skid stage
  always_comb begin
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      state_d[i] = state_q[i];
      len_d[i]   = len_q[i];
    end
    wr_active_d = wr_active_q;
    wr_cur_d    = wr_cur_q;
    wr_ptr_d    = wr_ptr_q;
    wr_ovf_d    = wr_ovf_q;
    mem_we      = 1'b0;
    mem_waddr   = {wr_cur_q, wr_ptr_q[OW-1:0]};
    rd_active_d = rd_active_q;
    rd_cur_d    = rd_cur_q;
    rd_fptr_d   = rd_fptr_q;
    rd_err_d    = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    mem_raddr   = {rd_cur_q, rd_fptr_q[OW-1:0]};
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    pop         = out_vld_q && rd_ready;
    rd_accept   = rd_start && !rd_active_q;
    // Beats held in or heading for the output/skid pair after this cycle
    occ         = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q) - 2'(pop);
    credit_ok   = (occ <= 2'd1);

    if (wr_start && slot_free) begin
      state_d[first_free] = S_WRITING;
      wr_active_d         = 1'b1;
      wr_cur_d            = first_free;
      wr_ptr_d            = '0;
      wr_ovf_d            = 1'b0;
    end else if (wr_active_q) begin
      if (wr_data_valid) begin
        if (wr_ptr_q == LW'(SLOT_BYTES)) begin
          wr_ovf_d = 1'b1;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + LW'(1);
        end
      end
      if (wr_finish) begin
        wr_active_d      = 1'b0;
        len_d[wr_cur_q]  = wr_ptr_d;
        state_d[wr_cur_q] = (wr_ptr_d == '0) ? S_FREE : S_VALID;
      end
    end

    // Invalidate overrides a same-cycle finish; READING/FREE slots are untouched
    if (inv_valid) begin
      if (state_q[inv_slot] == S_WRITING) begin
        state_d[inv_slot] = S_FREE;
        wr_active_d       = 1'b0;
      end else if (state_q[inv_slot] == S_VALID) begin
        state_d[inv_slot] = S_FREE;
      end
    end

    // A read accept on a VALID slot takes precedence over a same-cycle invalidate
    if (rd_accept) begin
      if (state_q[rd_slot] == S_VALID) begin
        state_d[rd_slot] = S_READING;
        rd_active_d      = 1'b1;
        rd_cur_d         = rd_slot;
        issue            = 1'b1;
        issue_last       = (len_q[rd_slot] == LW'(1));
        mem_raddr        = {rd_slot, OW'(0)};
        rd_fptr_d        = LW'(1);
      end else begin
        rd_err_d = 1'b1;
      end
    end else if (rd_active_q) begin
      if ((rd_fptr_q != len_q[rd_cur_q]) && credit_ok) begin
        issue      = 1'b1;
        issue_last = ((rd_fptr_q + LW'(1)) == len_q[rd_cur_q]);
        rd_fptr_d  = rd_fptr_q + LW'(1);
      end
      if (pop && out_last_q) begin
        state_d[rd_cur_q] = S_FREE;
        rd_active_d       = 1'b0;
      end
    end

    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_data_d  = skid_data_q;
        out_last_d  = skid_last_q;
        skid_vld_d  = ram_vld_q;
        skid_data_d = ram_data_q;
        skid_last_d = ram_last_q;
      end else begin
        out_vld_d  = ram_vld_q;
        out_last_d = ram_vld_q && ram_last_q;
        if (ram_vld_q) begin
          out_data_d = ram_data_q;
        end
      end
    end else if (ram_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_data_d = ram_data_q;
      skid_last_d = ram_last_q;
    end

    free_count_d = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (state_d[i] == S_FREE) begin
        free_count_d = free_count_d + CW'(1);
      end
    end
  end

  // Byte storage: synchronous write port and registered read port
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= wr_data;
    end
    if (issue) begin
      ram_data_q <= mem[mem_raddr];
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        state_q[i] <= S_FREE;
        len_q[i]   <= '0;
      end
      free_count_q <= CW'(NUM_SLOTS);
      wr_active_q  <= 1'b0;
      wr_cur_q     <= '0;
      wr_ptr_q     <= '0;
      wr_ovf_q     <= 1'b0;
      rd_active_q  <= 1'b0;
      rd_cur_q     <= '0;
      rd_fptr_q    <= '0;
      rd_err_q     <= 1'b0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        state_q[i] <= state_d[i];
        len_q[i]   <= len_d[i];
      end
      free_count_q <= free_count_d;
      wr_active_q  <= wr_active_d;
      wr_cur_q     <= wr_cur_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_ovf_q     <= wr_ovf_d;
      rd_active_q  <= rd_active_d;
      rd_cur_q     <= rd_cur_d;
      rd_fptr_q    <= rd_fptr_d;
      rd_err_q     <= rd_err_d;
      ram_vld_q    <= issue;
      ram_last_q   <= issue_last;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

endmodule
